// File: rtl/pong_pkg.sv
// Shared Pong definitions: bounce command codes, screen/paddle geometry and
// the referee state encoding.
package pong_pkg;

  typedef logic [1:0] bounce_t;

  localparam bounce_t BOUNCE_NONE   = 2'b00;
  localparam bounce_t BOUNCE_PADDLE = 2'b01;
  localparam bounce_t BOUNCE_WALL   = 2'b10;
  localparam bounce_t BOUNCE_SCORE  = 2'b11;

  localparam int unsigned SCREEN_X_DEF      = 640;
  localparam int unsigned SCREEN_Y_DEF      = 480;
  localparam int unsigned PADDLE_W_DEF      = 8;
  localparam int unsigned PADDLE_H_DEF      = 64;
  localparam int unsigned LEFT_PADDLE_X_DEF = 16;
  localparam int unsigned RIGHT_PADDLE_X_DEF = 616;
  localparam int unsigned BALL_SPEED_DEF    = 5;
  localparam int unsigned WIN_SCORE_DEF     = 9;

  // Coordinates at or above this value are a 10-bit underflow past zero.
  localparam logic [9:0] UNDERFLOW_LIMIT = 10'd1000;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    HOLD      = 2'd1,
    SERVE     = 2'd2,
    GAME_OVER = 2'd3
  } ref_state_t;

endpackage

// File: rtl/pong_referee_if.sv
// Signal bundle between the referee, the ball/paddle FSMs and the score overlay.
interface pong_referee_if;
  import pong_pkg::*;

  logic       restart;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic [7:0] size_x;
  logic [7:0] size_y;
  logic [9:0] left_pad_y;
  logic [9:0] right_pad_y;
  bounce_t    bounce;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic       game_over;

  modport master (
    output restart, pos_x, pos_y, size_x, size_y, left_pad_y, right_pad_y,
    input  bounce, score_left, score_right, game_over
  );

  modport slave (
    input  restart, pos_x, pos_y, size_x, size_y, left_pad_y, right_pad_y,
    output bounce, score_left, score_right, game_over
  );

endinterface

// File: rtl/pong_collision_detect.sv
// Purely combinational geometry tests: goals on either side, paddle contact
// and wall contact for the current ball box. All sums are 11 bits wide.
module pong_collision_detect
  import pong_pkg::*;
#(
  parameter int unsigned SCREEN_X       = SCREEN_X_DEF,
  parameter int unsigned SCREEN_Y       = SCREEN_Y_DEF,
  parameter int unsigned PADDLE_W       = PADDLE_W_DEF,
  parameter int unsigned PADDLE_H       = PADDLE_H_DEF,
  parameter int unsigned LEFT_PADDLE_X  = LEFT_PADDLE_X_DEF,
  parameter int unsigned RIGHT_PADDLE_X = RIGHT_PADDLE_X_DEF
) (
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  input  logic [7:0] size_x,
  input  logic [7:0] size_y,
  input  logic [9:0] left_pad_y,
  input  logic [9:0] right_pad_y,
  output logic       goal_l,
  output logic       goal_r,
  output logic       hit,
  output logic       wall
);

  localparam logic [10:0] EDGE_X     = 11'(SCREEN_X);
  localparam logic [10:0] EDGE_Y     = 11'(SCREEN_Y);
  localparam logic [10:0] PAD_H      = 11'(PADDLE_H);
  localparam logic [10:0] LEFT_FACE  = 11'(LEFT_PADDLE_X + PADDLE_W);
  localparam logic [10:0] RIGHT_FACE = 11'(RIGHT_PADDLE_X);

  logic [10:0] ball_right;
  logic [10:0] ball_bottom;
  logic [10:0] ball_top;
  logic [10:0] ball_left;
  logic [10:0] lpad_top;
  logic [10:0] rpad_top;
  logic        hit_l;
  logic        hit_r;

  assign ball_left   = {1'b0, pos_x};
  assign ball_top    = {1'b0, pos_y};
  assign ball_right  = ball_left + {3'b000, size_x};
  assign ball_bottom = ball_top + {3'b000, size_y};
  assign lpad_top    = {1'b0, left_pad_y};
  assign rpad_top    = {1'b0, right_pad_y};

  assign goal_l = (pos_x == '0) || (pos_x >= UNDERFLOW_LIMIT);
  assign goal_r = !goal_l && (ball_right >= EDGE_X);

  assign hit_l = (ball_left == LEFT_FACE) && (ball_bottom > lpad_top) &&
                 (ball_top < lpad_top + PAD_H);
  assign hit_r = (ball_right == RIGHT_FACE) && (ball_bottom > rpad_top) &&
                 (ball_top < rpad_top + PAD_H);
  assign hit   = hit_l || hit_r;

  assign wall = (pos_y == '0) || (pos_y >= UNDERFLOW_LIMIT) || (ball_bottom >= EDGE_Y);

endmodule

// File: rtl/pong_referee.sv
// Pong referee: classifies collisions/goals, holds each bounce command for one
// ball move period, and keeps the scores and game-over condition.
module pong_referee
  import pong_pkg::*;
#(
  parameter int unsigned SCREEN_X       = SCREEN_X_DEF,
  parameter int unsigned SCREEN_Y       = SCREEN_Y_DEF,
  parameter int unsigned PADDLE_W       = PADDLE_W_DEF,
  parameter int unsigned PADDLE_H       = PADDLE_H_DEF,
  parameter int unsigned LEFT_PADDLE_X  = LEFT_PADDLE_X_DEF,
  parameter int unsigned RIGHT_PADDLE_X = RIGHT_PADDLE_X_DEF,
  parameter int unsigned BALL_SPEED     = BALL_SPEED_DEF,
  parameter int unsigned WIN_SCORE      = WIN_SCORE_DEF
) (
  input  logic           clock,
  input  logic           reset,
  pong_referee_if.slave  bus
);

  localparam logic [7:0] HOLD_CLOCKS = 8'(BALL_SPEED);
  localparam logic [3:0] WIN         = 4'(WIN_SCORE);

  logic goal_l, goal_r, hit, wall;

  pong_collision_detect #(
    .SCREEN_X       (SCREEN_X),
    .SCREEN_Y       (SCREEN_Y),
    .PADDLE_W       (PADDLE_W),
    .PADDLE_H       (PADDLE_H),
    .LEFT_PADDLE_X  (LEFT_PADDLE_X),
    .RIGHT_PADDLE_X (RIGHT_PADDLE_X)
  ) u_detect (
    .pos_x       (bus.pos_x),
    .pos_y       (bus.pos_y),
    .size_x      (bus.size_x),
    .size_y      (bus.size_y),
    .left_pad_y  (bus.left_pad_y),
    .right_pad_y (bus.right_pad_y),
    .goal_l      (goal_l),
    .goal_r      (goal_r),
    .hit         (hit),
    .wall        (wall)
  );

  ref_state_t state, state_n;
  logic [7:0] timer, timer_n;
  bounce_t    code, code_n;
  bounce_t    bounce_q, bounce_n;
  logic [3:0] score_l, score_l_n;
  logic [3:0] score_r, score_r_n;
  logic       over_q, over_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= PLAY;
      timer    <= '0;
      code     <= BOUNCE_NONE;
      bounce_q <= BOUNCE_NONE;
      score_l  <= '0;
      score_r  <= '0;
      over_q   <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      code     <= code_n;
      bounce_q <= bounce_n;
      score_l  <= score_l_n;
      score_r  <= score_r_n;
      over_q   <= over_n;
    end
  end

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    code_n    = code;
    score_l_n = score_l;
    score_r_n = score_r;

    unique case (state)
      PLAY: begin
        if (goal_l || goal_r) begin
          if (goal_l) score_r_n = score_r + 4'd1;
          else        score_l_n = score_l + 4'd1;
          if ((goal_l ? score_r_n : score_l_n) == WIN) begin
            state_n = GAME_OVER;
          end else begin
            state_n = SERVE;
            timer_n = HOLD_CLOCKS;
          end
        end else if (hit || wall) begin
          state_n = HOLD;
          code_n  = hit ? BOUNCE_PADDLE : BOUNCE_WALL;
          timer_n = HOLD_CLOCKS;
        end
      end
      HOLD, SERVE: begin
        timer_n = timer - 8'd1;
        if (timer == 8'd1) state_n = PLAY;
      end
      GAME_OVER: begin
        if (bus.restart) begin
          score_l_n = '0;
          score_r_n = '0;
          state_n   = SERVE;
          timer_n   = HOLD_CLOCKS;
        end
      end
      default: state_n = PLAY;
    endcase

    // Outputs are registered from the next state so they align with it.
    unique case (state_n)
      HOLD:            bounce_n = code_n;
      SERVE, GAME_OVER: bounce_n = BOUNCE_SCORE;
      default:         bounce_n = BOUNCE_NONE;
    endcase
    over_n = (state_n == GAME_OVER);
  end

  assign bus.bounce      = bounce_q;
  assign bus.score_left  = score_l;
  assign bus.score_right = score_r;
  assign bus.game_over   = over_q;

endmodule

// File: tb/tb_pong_referee.sv
// Scoreboard bench for pong_referee: a reference model predicts the outputs
// after each clock edge; predictions are queued and compared after the edge.
module tb_pong_referee;

  localparam int BS  = 5;
  localparam int WIN = 9;

  typedef struct {
    int bounce;
    int sl;
    int sr;
    int go;
  } exp_t;

  logic clk;
  logic rst;
  pong_referee_if bus();

  pong_referee #(
    .BALL_SPEED (BS),
    .WIN_SCORE  (WIN)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  exp_t sb[$];

  // model: 0 play, 1 hold, 2 serve, 3 game over
  int m_mode, m_rem, m_code, m_sl, m_sr;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // 0 none, 1 paddle, 2 wall, 10 right player scores, 11 left player scores
  function automatic int classify(int px, int py, int sx, int sy, int lp, int rp);
    bool_l: begin end
    if (px == 0 || px >= 1000) return 10;
    if (px + sx >= 640) return 11;
    if (px == 24 && py + sy > lp && py < lp + 64) return 1;
    if (px + sx == 616 && py + sy > rp && py < rp + 64) return 1;
    if (py == 0 || py >= 1000 || py + sy >= 480) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_rem = 0; m_code = 0; m_sl = 0; m_sr = 0;
  endtask

  task automatic model_step();
    int ev;
    case (m_mode)
      0: begin
        ev = classify(int'(bus.pos_x), int'(bus.pos_y), int'(bus.size_x),
                      int'(bus.size_y), int'(bus.left_pad_y), int'(bus.right_pad_y));
        if (ev >= 10) begin
          if (ev == 10) m_sr++; else m_sl++;
          if (m_sl == WIN || m_sr == WIN) m_mode = 3;
          else begin m_mode = 2; m_rem = BS; end
        end else if (ev != 0) begin
          m_mode = 1; m_code = ev; m_rem = BS;
        end
      end
      1, 2: begin
        m_rem--;
        if (m_rem == 0) m_mode = 0;
      end
      default: begin
        if (bus.restart) begin
          m_sl = 0; m_sr = 0; m_mode = 2; m_rem = BS;
        end
      end
    endcase
  endtask

  task automatic tick();
    exp_t e;
    model_step();
    e.bounce = (m_mode == 0) ? 0 : (m_mode == 1) ? m_code : 3;
    e.sl = m_sl;
    e.sr = m_sr;
    e.go = (m_mode == 3) ? 1 : 0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq("bounce", int'(bus.bounce), e.bounce);
    check_eq("score_left", int'(bus.score_left), e.sl);
    check_eq("score_right", int'(bus.score_right), e.sr);
    check_eq("game_over", int'(bus.game_over), e.go);
  endtask

  task automatic set_ball(input int px, input int py, input int sx, input int sy,
                          input int lp, input int rp);
    bus.pos_x       = 10'(px);
    bus.pos_y       = 10'(py);
    bus.size_x      = 8'(sx);
    bus.size_y      = 8'(sy);
    bus.left_pad_y  = 10'(lp);
    bus.right_pad_y = 10'(rp);
  endtask

  task automatic idle(input int n);
    set_ball(300, 200, 8, 8, 180, 180);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic shot(input int px, input int py, input int sx, input int sy,
                      input int lp, input int rp);
    set_ball(px, py, sx, sy, lp, rp);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.restart = 1'b0;
    set_ball(300, 200, 8, 8, 180, 180);
    model_reset();
    #12;
    check_eq("reset_bounce", int'(bus.bounce), 0);
    check_eq("reset_score_left", int'(bus.score_left), 0);
    check_eq("reset_score_right", int'(bus.score_right), 0);
    check_eq("reset_game_over", int'(bus.game_over), 0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // left paddle hit
    shot(24, 200, 8, 8, 180, 180);
    check_eq("left_hit_code", int'(bus.bounce), 1);
    idle(6);
    // right paddle hit
    shot(608, 100, 8, 8, 180, 60);
    idle(6);
    // paddle miss (ball below left paddle) is no event
    shot(24, 300, 8, 8, 180, 180);
    idle(1);
    // top wall, bottom wall, underflowed top
    shot(300, 0, 8, 8, 180, 180);
    check_eq("top_wall_code", int'(bus.bounce), 2);
    idle(6);
    shot(300, 472, 8, 8, 180, 180);
    idle(6);
    shot(300, 1020, 8, 8, 180, 180);
    idle(6);
    // corner: paddle wins over wall
    shot(24, 0, 8, 8, 0, 180);
    check_eq("corner_code", int'(bus.bounce), 1);
    idle(6);
    // goals on the left side, both via zero and via underflow
    shot(0, 200, 8, 8, 180, 180);
    check_eq("goal0_score_right", int'(bus.score_right), 1);
    idle(6);
    shot(1023, 200, 8, 8, 180, 180);
    idle(6);
    // restart in PLAY is ignored
    bus.restart = 1'b1;
    idle(1);
    bus.restart = 1'b0;
    idle(1);
    // left scores three times -> 3/2, then async reset mid-HOLD
    for (int g = 0; g < 3; g++) begin
      shot(632, 200, 8, 8, 180, 180);
      idle(6);
    end
    shot(24, 200, 8, 8, 180, 180);
    idle(2);
    #1;
    rst = 1'b1;
    #1;
    check_eq("async_bounce", int'(bus.bounce), 0);
    check_eq("async_score_left", int'(bus.score_left), 0);
    check_eq("async_score_right", int'(bus.score_right), 0);
    check_eq("async_game_over", int'(bus.game_over), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    // left wins 9-0
    for (int g = 0; g < 8; g++) begin
      shot(632, 200, 8, 8, 180, 180);
      idle(6);
    end
    shot(632, 200, 8, 8, 180, 180);
    check_eq("win_score_left", int'(bus.score_left), 9);
    check_eq("win_game_over", int'(bus.game_over), 1);
    shot(24, 200, 8, 8, 180, 180);
    idle(10);
    // restart out of GAME_OVER
    bus.restart = 1'b1;
    idle(1);
    bus.restart = 1'b0;
    check_eq("restart_score_left", int'(bus.score_left), 0);
    check_eq("restart_game_over", int'(bus.game_over), 0);
    idle(8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
